// File: rtl/temp_cmd_gen.sv
// Pushbutton front end for the temperature range counter: synchronizes and debounces
// up/down/load buttons, then issues single-cycle commands with hold-to-repeat on up/down.
module temp_cmd_gen #(
  parameter int DB_CYCLES     = 500000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_dn,
  input  logic       btn_ld,
  input  logic [3:0] temp,
  output logic       cup,
  output logic       cdown,
  output logic       load,
  output logic       rpt_active
);

  localparam int DB_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  // Bit order in the button vectors: [0]=up, [1]=down, [2]=load.
  localparam int B_UP = 0;
  localparam int B_DN = 1;
  localparam int B_LD = 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  logic [2:0]      w_btn_raw;
  logic [2:0]      r_sync1;
  logic [2:0]      r_sync2;
  logic [2:0]      r_db;
  logic [2:0]      r_db_q;
  logic [DB_W-1:0] r_db_cnt [3];
  logic [2:0]      w_rise;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_dir_dn;
  logic            w_dir_nxt;
  logic [TMR_W-1:0] r_tmr;
  logic [TMR_W-1:0] w_tmr_nxt;
  logic            w_pulse;
  logic            w_conflict;
  logic            w_held;

  logic            w_cup_nxt;
  logic            w_cdown_nxt;
  logic            w_load_nxt;
  logic            w_rpt_nxt;

  assign w_btn_raw  = {btn_ld, btn_dn, btn_up};
  assign w_rise     = r_db & ~r_db_q;
  assign w_conflict = r_db[B_UP] & r_db[B_DN];
  assign w_held     = r_dir_dn ? r_db[B_DN] : r_db[B_UP];

  // Synchronizers and per-button debounce counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_db_q  <= '0;
      for (int i = 0; i < 3; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
      r_db_q  <= r_db;
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_W'(DB_CYCLES - 1)) begin
          r_db[i]     <= ~r_db[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_dir_dn   <= 1'b0;
      r_tmr      <= '0;
      cup        <= 1'b0;
      cdown      <= 1'b0;
      load       <= 1'b0;
      rpt_active <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_dir_dn   <= w_dir_nxt;
      r_tmr      <= w_tmr_nxt;
      cup        <= w_cup_nxt;
      cdown      <= w_cdown_nxt;
      load       <= w_load_nxt;
      rpt_active <= w_rpt_nxt;
    end
  end

  // Next-state logic; w_pulse marks a transition that issues a command
  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir_dn;
    w_tmr_nxt   = r_tmr;
    w_pulse     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_conflict && (w_rise[B_UP] || w_rise[B_DN])) begin
          w_state_nxt = S_DELAY;
          w_dir_nxt   = w_rise[B_DN];
          w_tmr_nxt   = '0;
          w_pulse     = 1'b1;
        end
      end
      S_DELAY: begin
        if (w_conflict || !w_held) begin
          w_state_nxt = S_IDLE;
          w_tmr_nxt   = '0;
        end else if (r_tmr == TMR_W'(REPEAT_DELAY - 1)) begin
          w_state_nxt = S_REPEAT;
          w_tmr_nxt   = '0;
          w_pulse     = 1'b1;
        end else begin
          w_tmr_nxt = r_tmr + TMR_W'(1);
        end
      end
      S_REPEAT: begin
        if (w_conflict || !w_held) begin
          w_state_nxt = S_IDLE;
          w_tmr_nxt   = '0;
        end else if (r_tmr == TMR_W'(REPEAT_PERIOD - 1)) begin
          w_tmr_nxt = '0;
          w_pulse   = 1'b1;
        end else begin
          w_tmr_nxt = r_tmr + TMR_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tmr_nxt   = '0;
      end
    endcase
  end

  // Load wins over a same-cycle up/down pulse, which is simply lost; saturation only masks the command
  always_comb begin
    w_load_nxt  = w_rise[B_LD];
    w_cup_nxt   = w_pulse & ~w_dir_nxt & ~w_load_nxt & (temp != 4'hF);
    w_cdown_nxt = w_pulse &  w_dir_nxt & ~w_load_nxt & (temp != 4'h0);
    w_rpt_nxt   = (w_state_nxt == S_REPEAT);
  end

endmodule
